// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared constants, FSM state type and the output byte conversion for the
// 4x4 output-stationary systolic multiplier.
//
// Configuration macro: SA_SATURATE_OUT_EN
//   defined   -> output byte saturates to 8'hFF when the accumulator exceeds 255
//   undefined -> output byte is the low 8 bits of the accumulator (wraps)
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int N  = 4;   // array dimension; load/output framing assumes 4
  localparam int DW = 8;   // operand / output byte width
  localparam int AW = 18;  // accumulator width, holds 4*255*255

  // Counter widths for the three timed phases.
  localparam int LOAD_CW = 4;
  localparam int PUMP_CW = 4;
  localparam int OUT_CW  = 4;

  // Cycles needed for the last skewed operand pair to reach PE(N-1,N-1).
  localparam int PUMP_CYCLES = 3 * N - 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PUMP = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Converts a finished accumulator to the byte placed on the output stream.
  function automatic logic [DW-1:0] acc_to_byte(input logic [AW-1:0] acc);
`ifdef SA_SATURATE_OUT_EN
    return (acc > AW'(255)) ? {DW{1'b1}} : DW'(acc);
`else
    return DW'(acc);
`endif
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// ---------------------------------------------------------------------------
// systolic_pe
// One multiply-accumulate cell of the output-stationary array.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear of accumulator and pass-through registers
//   en        : when high, acc += a_in*b_in and a/b are forwarded
//   a_in/a_out: A operand entering from the left, leaving to the right
//   b_in/b_out: B operand entering from the top, leaving downward
//   acc       : running accumulator
// ---------------------------------------------------------------------------
module systolic_pe
  import systolic_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [2*DW-1:0] prod;

  always_comb begin
    prod  = (2*DW)'(a_in) * (2*DW)'(b_in);
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_4x4.sv
// ---------------------------------------------------------------------------
// systolic_array_4x4
// 4x4 output-stationary systolic multiplier, C = A x B on unsigned bytes.
//   clk_p        : clock, rising edge
//   rst_p        : asynchronous active-high reset, aborts any job
//   en_p         : start qualifier, sampled only in IDLE and DONE
//   p_shift_in_A : A byte stream, beat k = A[k/4][3-k%4]
//   p_shift_in_B : B byte stream, beat k = B[3-k%4][k/4]
//   p_shift_out  : C byte stream, row-major, registered
//   ack_p        : high while p_shift_out carries a C element
//
// Handshake: there is no backpressure. en_p high in IDLE/DONE starts a job and
// its first beat is captured on that edge; the next 15 edges capture beats
// 1..15 regardless of en_p. ack_p is high for exactly 16 consecutive cycles,
// one element per cycle, starting 11 cycles after the last load beat.
//
// Configuration macro: SA_SATURATE_OUT_EN (saturating output byte, see pkg).
// ---------------------------------------------------------------------------
module systolic_array_4x4
  import systolic_pkg::*;
(
  input  logic          clk_p,
  input  logic          rst_p,
  input  logic          en_p,
  input  logic [DW-1:0] p_shift_in_A,
  input  logic [DW-1:0] p_shift_in_B,
  output logic [DW-1:0] p_shift_out,
  output logic          ack_p
);

  state_e               state_q, state_d;
  logic [LOAD_CW-1:0]   load_cnt_q, load_cnt_d;
  logic [PUMP_CW-1:0]   pump_cnt_q, pump_cnt_d;
  logic [OUT_CW-1:0]    out_cnt_q, out_cnt_d;
  logic [DW-1:0]        out_q, out_d;
  logic                 ack_q, ack_d;

  // a_buf[r][k] = A[r][k]; b_buf[c][k] = B[k][c] once loading completes.
  logic [DW-1:0]        a_buf_q [N][N];
  logic [DW-1:0]        a_buf_d [N][N];
  logic [DW-1:0]        b_buf_q [N][N];
  logic [DW-1:0]        b_buf_d [N][N];

  logic                 cap;
  logic [LOAD_CW-1:0]   cap_k;
  logic                 pe_clr;
  logic                 pe_en;

  logic [DW-1:0]        a_edge [N];
  logic [DW-1:0]        b_edge [N];
  logic [DW-1:0]        a_h    [N][N+1];
  logic [DW-1:0]        b_v    [N+1][N];
  logic [AW-1:0]        acc_w  [N*N];

  // FSM next-state and control.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    pump_cnt_d = pump_cnt_q;
    out_cnt_d  = out_cnt_q;
    ack_d      = 1'b0;
    out_d      = '0;
    cap        = 1'b0;
    cap_k      = load_cnt_q;
    pe_clr     = 1'b0;
    pe_en      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (en_p) begin
          // Start edge: beat 0 is captured and the array is wiped so a
          // previous job cannot leak into this one.
          state_d    = LOAD;
          cap        = 1'b1;
          cap_k      = '0;
          load_cnt_d = LOAD_CW'(1);
          pe_clr     = 1'b1;
        end
      end
      LOAD: begin
        cap        = 1'b1;
        load_cnt_d = load_cnt_q + LOAD_CW'(1);
        if (load_cnt_q == LOAD_CW'(N*N-1)) begin
          state_d    = PUMP;
          pump_cnt_d = '0;
        end
      end
      PUMP: begin
        pe_en      = 1'b1;
        pump_cnt_d = pump_cnt_q + PUMP_CW'(1);
        if (pump_cnt_q == PUMP_CW'(PUMP_CYCLES-1)) begin
          state_d   = OUT;
          out_cnt_d = '0;
        end
      end
      OUT: begin
        ack_d     = 1'b1;
        out_d     = acc_to_byte(acc_w[out_cnt_q]);
        out_cnt_d = out_cnt_q + OUT_CW'(1);
        if (out_cnt_q == OUT_CW'(N*N-1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand buffers: each beat shifts into buffer[k/4] at slot 0, so the
  // last-sent element (element 0) ends up at the head.
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (cap) begin
      for (int r = 0; r < N; r++) begin
        if (cap_k[3:2] == 2'(r)) begin
          for (int j = N-1; j > 0; j--) begin
            a_buf_d[r][j] = a_buf_q[r][j-1];
            b_buf_d[r][j] = b_buf_q[r][j-1];
          end
          a_buf_d[r][0] = p_shift_in_A;
          b_buf_d[r][0] = p_shift_in_B;
        end
      end
    end
  end

  // Skew: row r / column c sees element k at pump cycle r+k / c+k, zeros
  // outside that window.
  always_comb begin
    for (int r = 0; r < N; r++) begin : g_skew
      int k;
      k         = int'(pump_cnt_q) - r;
      a_edge[r] = '0;
      b_edge[r] = '0;
      if (state_q == PUMP && k >= 0 && k < N) begin
        a_edge[r] = a_buf_q[r][k[1:0]];
        b_edge[r] = b_buf_q[r][k[1:0]];
      end
    end
  end

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      pump_cnt_q <= '0;
      out_cnt_q  <= '0;
      out_q      <= '0;
      ack_q      <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int j = 0; j < N; j++) begin
          a_buf_q[r][j] <= '0;
          b_buf_q[r][j] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      pump_cnt_q <= pump_cnt_d;
      out_cnt_q  <= out_cnt_d;
      out_q      <= out_d;
      ack_q      <= ack_d;
      a_buf_q    <= a_buf_d;
      b_buf_q    <= b_buf_d;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_edge
    assign a_h[r][0] = a_edge[r];
    assign b_v[0][r] = b_edge[r];
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      systolic_pe u_pe (
        .clk   (clk_p),
        .rst   (rst_p),
        .clr   (pe_clr),
        .en    (pe_en),
        .a_in  (a_h[r][c]),
        .b_in  (b_v[r][c]),
        .a_out (a_h[r][c+1]),
        .b_out (b_v[r+1][c]),
        .acc   (acc_w[r*N+c])
      );
    end
  end

  assign p_shift_out = out_q;
  assign ack_p       = ack_q;

endmodule

// File: tb/tb_systolic_array_4x4.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_4x4
// Self-checking bench: directed and random matrices, reference product
// computed with plain integer loops, outputs compared through a queue.
// ---------------------------------------------------------------------------
module tb_systolic_array_4x4;

  logic       clk_p = 1'b0;
  logic       rst_p;
  logic       en_p;
  logic [7:0] p_shift_in_A;
  logic [7:0] p_shift_in_B;
  logic [7:0] p_shift_out;
  logic       ack_p;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         mat_a[4][4];
  int         mat_b[4][4];

  // Clock / reset
  always #5 clk_p = ~clk_p;

  systolic_array_4x4 dut (
    .clk_p        (clk_p),
    .rst_p        (rst_p),
    .en_p         (en_p),
    .p_shift_in_A (p_shift_in_A),
    .p_shift_in_B (p_shift_in_B),
    .p_shift_out  (p_shift_out),
    .ack_p        (ack_p)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: matrix product, then the output byte rule.
  function automatic int ref_elem(input int r, input int c);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += mat_a[r][k] * mat_b[k][c];
`ifdef SA_SATURATE_OUT_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic model_job();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(8'(ref_elem(r, c)));
  endtask

  // Drivers
  task automatic drive_load(input bit hold_en);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_p);
      en_p         = (k == 0) ? 1'b1 : hold_en;
      p_shift_in_A = 8'(mat_a[k/4][3-(k%4)]);
      p_shift_in_B = 8'(mat_b[3-(k%4)][k/4]);
    end
  endtask

  task automatic quiet_inputs();
    en_p         = 1'b0;
    p_shift_in_A = 8'd0;
    p_shift_in_B = 8'd0;
  endtask

  // Waits for ack_p, checks latency, drains the expected queue.
  task automatic collect(input string tag);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk_p);
      quiet_inputs();
      cyc++;
      if (ack_p === 1'b1) seen = 1;
    end
    if (!seen) begin
      check_val({tag, "_ack_timeout"}, 0, 1);
      exp_q.delete();
      return;
    end
    // ack_p rises 11 edges after the last-beat edge.
    check_val({tag, "_latency"}, cyc - 1, 11);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk_p);
      check_val({tag, "_ack"}, ack_p, 1);
      check_val({tag, "_data"}, p_shift_out, exp_q.pop_front());
    end
    @(negedge clk_p);
    check_val({tag, "_ack_drop"}, ack_p, 0);
    check_val({tag, "_out_zero"}, p_shift_out, 0);
  endtask

  task automatic run_job(input bit hold_en, input string tag);
    model_job();
    drive_load(hold_en);
    collect(tag);
  endtask

  task automatic set_test1();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = j + 1;
        mat_b[i][j] = i + 1;
      end
  endtask

  task automatic set_random(input int max_val);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = int'($urandom_range(0, max_val));
        mat_b[i][j] = int'($urandom_range(0, max_val));
      end
  endtask

  task automatic watch_no_ack(input string tag, input int cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_p);
      if (ack_p !== 1'b0) seen = 1;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    int wait_cyc;
    rst_p = 1'b1;
    quiet_inputs();
    repeat (2) @(negedge clk_p);
    check_val("rst_ack", ack_p, 0);
    check_val("rst_out", p_shift_out, 0);
    rst_p = 1'b0;
    watch_no_ack("idle_no_ack", 5);

    // Test 1: rows [1 2 3 4] times constant rows -> all 30
    set_test1();
    run_job(1'b1, "t1");

    // Test 2: border-ones A, B[i][j] = 2*(4i+j)+12
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = (i == 0 || i == 3 || j == 0 || j == 3) ? 1 : 0;
        mat_b[i][j] = 2 * (4 * i + j) + 12;
      end
    run_job(1'b1, "t2");

    // Test 3: ramp A, sparse B; en_p dropped after beat 0
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 3 * (4 * i + j);
        mat_b[i][j] = 0;
      end
    mat_b[0][0] = 2; mat_b[0][3] = 1;
    mat_b[1][1] = 2; mat_b[1][2] = 1;
    mat_b[2][1] = 1; mat_b[2][2] = 2;
    mat_b[3][0] = 1; mat_b[3][3] = 2;
    run_job(1'b0, "t3");

    // Test 4: all 255 -> wrap or saturate
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 255;
        mat_b[i][j] = 255;
      end
    run_job(1'b1, "t4");

    // Test 5a: reset during PUMP, no output afterwards
    set_test1();
    drive_load(1'b1);
    @(negedge clk_p);
    quiet_inputs();
    repeat (3) @(negedge clk_p);
    #1 rst_p = 1'b1;
    #1;
    check_val("rst_pump_ack", ack_p, 0);
    check_val("rst_pump_out", p_shift_out, 0);
    @(negedge clk_p);
    rst_p = 1'b0;
    watch_no_ack("rst_pump_no_partial", 30);
    run_job(1'b1, "t5a");

    // Test 5b: reset while results stream out
    drive_load(1'b1);
    wait_cyc = 0;
    while (ack_p !== 1'b1 && wait_cyc < 40) begin
      @(negedge clk_p);
      quiet_inputs();
      wait_cyc++;
    end
    check_val("rst_out_reached_ack", ack_p, 1);
    repeat (3) @(negedge clk_p);
    #1 rst_p = 1'b1;
    #1;
    check_val("rst_out_ack", ack_p, 0);
    check_val("rst_out_out", p_shift_out, 0);
    @(negedge clk_p);
    rst_p = 1'b0;
    watch_no_ack("rst_out_no_partial", 30);
    run_job(1'b1, "t5b");

    // Test 6: back-to-back random jobs restarted from DONE
    for (int j = 0; j < 6; j++) begin
      set_random((j % 2 == 0) ? 255 : 15);
      run_job(1'($urandom_range(0, 1)), "t6");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
